// File: rtl/elevator_call_dispatcher.sv
// Call-side dispatcher for the elevator car: latches floor calls, picks the travel
// direction and drives the car's sobe/desce/pa commands, holding a sticky fault on erro.
module elevator_call_dispatcher #(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]  floor,
  input  logic                floor_valid,
  input  logic                erro,
  output logic                sobe,
  output logic                desce,
  output logic                pa,
  output logic [N_FLOORS-1:0] pend,
  output logic                falha
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN,
    ST_DOOR,
    ST_FAULT
  } state_t;

  typedef enum logic {
    DIR_DOWN,
    DIR_UP
  } dir_t;

  state_t             state, state_d;
  dir_t               dir_last, dir_d;
  logic [CNT_W-1:0]   door_cnt, cnt_d;
  logic [FLOOR_W-1:0] floor_lat, cur_floor;
  logic [N_FLOORS-1:0] pend_d;
  logic               floor_bad, floor_ok, at_call, above, below;

  // An out-of-range index from the sensor is as untrustworthy as an explicit erro.
  assign floor_bad = floor_valid && (int'(floor) >= N_FLOORS);
  assign floor_ok  = floor_valid && !floor_bad;
  assign cur_floor = floor_ok ? floor : floor_lat;
  assign at_call   = floor_ok && pend[floor];

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pend[i] && (i > int'(cur_floor))) above = 1'b1;
      if (pend[i] && (i < int'(cur_floor))) below = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state;
    dir_d   = dir_last;
    cnt_d   = door_cnt;
    unique case (state)
      ST_IDLE: begin
        if (floor_ok && (pend != '0)) begin
          if (at_call) begin
            state_d = ST_DOOR;
            cnt_d   = CNT_LOAD;
          end else if (above) begin
            state_d = ST_UP;
          end else begin
            state_d = ST_DOWN;
          end
        end
      end
      ST_UP: begin
        if (at_call) begin
          state_d = ST_DOOR;
          cnt_d   = CNT_LOAD;
          dir_d   = DIR_UP;
        end else if (floor_ok && (floor == TOP_FLOOR)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DOWN: begin
        if (at_call) begin
          state_d = ST_DOOR;
          cnt_d   = CNT_LOAD;
          dir_d   = DIR_DOWN;
        end else if (floor_ok && (floor == '0)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DOOR: begin
        if (door_cnt == '0) begin
          // Keep sweeping the way we were going before reversing.
          if ((dir_last == DIR_UP) && above)        state_d = ST_UP;
          else if ((dir_last == DIR_DOWN) && below) state_d = ST_DOWN;
          else if (above)                           state_d = ST_UP;
          else if (below)                           state_d = ST_DOWN;
          else                                      state_d = ST_IDLE;
        end else begin
          cnt_d = door_cnt - 1'b1;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase
    if (erro || floor_bad) state_d = ST_FAULT;
  end

  always_comb begin
    pend_d = pend | btn;
    // Serving the floor clears its call even if the button is still pressed.
    if ((state == ST_DOOR) && floor_ok) pend_d[floor] = 1'b0;
    if (state_d == ST_FAULT) pend_d = '0;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir_last  <= DIR_UP;
      door_cnt  <= '0;
      pend      <= '0;
      floor_lat <= '0;
    end else begin
      state    <= state_d;
      dir_last <= dir_d;
      door_cnt <= cnt_d;
      pend     <= pend_d;
      if (floor_ok) floor_lat <= floor;
    end
  end

  always_comb begin
    sobe  = (state == ST_UP);
    desce = (state == ST_DOWN);
    pa    = (state == ST_DOOR) || (state == ST_FAULT);
    falha = (state == ST_FAULT);
  end

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed bench for elevator_call_dispatcher: the driver queues hand-computed
// per-cycle expectations, an independent monitor pops and compares them.
module tb_elevator_call_dispatcher;

  localparam logic [3:0] C_IDLE = 4'b0000;  // {sobe, desce, pa, falha}
  localparam logic [3:0] C_UP   = 4'b1000;
  localparam logic [3:0] C_DN   = 4'b0100;
  localparam logic [3:0] C_PA   = 4'b0010;
  localparam logic [3:0] C_FLT  = 4'b0011;

  typedef struct {
    logic [3:0] cmd;
    logic [3:0] pend;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, floor_valid, erro;
  logic [3:0] btn;
  logic [1:0] floor;
  logic       sobe, desce, pa, falha;
  logic [3:0] pend;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  elevator_call_dispatcher #(
    .N_FLOORS(4),
    .FLOOR_W(2),
    .DOOR_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .floor(floor),
    .floor_valid(floor_valid),
    .erro(erro),
    .sobe(sobe),
    .desce(desce),
    .pa(pa),
    .pend(pend),
    .falha(falha)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic [3:0] act_cmd;
    act_cmd = {sobe, desce, pa, falha};
    n_checks++;
    if ((act_cmd !== e.cmd) || (pend !== e.pend)) begin
      n_fail++;
      $display("FAIL %s: got cmd(sobe,desce,pa,falha)=%b pend=%b, expected cmd=%b pend=%b",
               e.name, act_cmd, pend, e.cmd, e.pend);
    end
  endtask

  // Monitor: outputs are stable at the falling edge, one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input logic [3:0] b, input logic [1:0] f, input logic v,
                     input logic er, input logic [3:0] c, input logic [3:0] p, input string nm);
    exp_t e;
    @(negedge clk);
    #1;
    rst         = r;
    btn         = b;
    floor       = f;
    floor_valid = v;
    erro        = er;
    e.cmd  = c;
    e.pend = p;
    e.name = nm;
    q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; btn = '0; floor = '0; floor_valid = 1'b0; erro = 1'b0;

    // Reset then idle
    cyc(1, 4'b0000, 0, 0, 0, C_IDLE, 4'b0000, "reset");
    for (int i = 0; i < 20; i++) cyc(0, 4'b0000, 0, 1, 0, C_IDLE, 4'b0000, "idle_hold");

    // Call above from floor 0 to floor 3
    cyc(0, 4'b1000, 0, 1, 0, C_IDLE, 4'b1000, "up_latch");
    cyc(0, 4'b0000, 0, 1, 0, C_UP,   4'b1000, "up_start");
    cyc(0, 4'b0000, 1, 1, 0, C_UP,   4'b1000, "up_f1");
    cyc(0, 4'b0000, 2, 1, 0, C_UP,   4'b1000, "up_f2");
    cyc(0, 4'b0000, 3, 1, 0, C_PA,   4'b1000, "up_arrive");
    cyc(0, 4'b0000, 3, 1, 0, C_PA,   4'b0000, "door_clear");
    cyc(0, 4'b0000, 3, 1, 0, C_PA,   4'b0000, "door_2");
    cyc(0, 4'b0000, 3, 1, 0, C_PA,   4'b0000, "door_3");
    cyc(0, 4'b0000, 3, 1, 0, C_IDLE, 4'b0000, "door_close");
    cyc(0, 4'b0000, 3, 1, 0, C_IDLE, 4'b0000, "idle_after");

    // Call at the current floor while idle
    cyc(0, 4'b0100, 2, 1, 0, C_IDLE, 4'b0100, "here_latch");
    cyc(0, 4'b0000, 2, 1, 0, C_PA,   4'b0100, "here_open");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 2, 1, 0, C_PA, 4'b0000, "here_door");
    cyc(0, 4'b0000, 2, 1, 0, C_IDLE, 4'b0000, "here_close");

    // Direction preference after up and down stops
    cyc(0, 4'b0000, 0, 1, 0, C_IDLE, 4'b0000, "reposition");
    cyc(0, 4'b0010, 0, 1, 0, C_IDLE, 4'b0010, "pref_latch");
    cyc(0, 4'b0000, 0, 1, 0, C_UP,   4'b0010, "pref_start");
    cyc(0, 4'b1001, 1, 1, 0, C_PA,   4'b1011, "stop_f1_up");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1, 1, 0, C_PA, 4'b1001, "door_f1_up");
    cyc(0, 4'b0000, 1, 1, 0, C_UP,   4'b1001, "pref_up");
    cyc(0, 4'b0000, 2, 1, 0, C_UP,   4'b1001, "pass_f2");
    cyc(0, 4'b0000, 3, 1, 0, C_PA,   4'b1001, "stop_f3");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 3, 1, 0, C_PA, 4'b0001, "door_f3");
    cyc(0, 4'b0000, 3, 1, 0, C_DN,   4'b0001, "turn_down");
    cyc(0, 4'b0010, 2, 1, 0, C_DN,   4'b0011, "down_f2");
    cyc(0, 4'b1000, 1, 1, 0, C_PA,   4'b1011, "stop_f1_down");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 1, 1, 0, C_PA, 4'b1001, "door_f1_down");
    cyc(0, 4'b0000, 1, 1, 0, C_DN,   4'b1001, "pref_down");
    cyc(0, 4'b0000, 0, 1, 0, C_PA,   4'b1001, "stop_f0");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 0, 1, 0, C_PA, 4'b1000, "door_f0");
    cyc(0, 4'b0000, 0, 1, 0, C_UP,   4'b1000, "reverse_up");
    cyc(0, 4'b0000, 3, 0, 0, C_UP,   4'b1000, "invalid_floor_ignored");
    cyc(0, 4'b0000, 1, 1, 0, C_UP,   4'b1000, "climb_f1");
    cyc(0, 4'b0000, 2, 1, 0, C_UP,   4'b1000, "climb_f2");
    cyc(0, 4'b0000, 3, 1, 0, C_PA,   4'b1000, "stop_top");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0000, 3, 1, 0, C_PA, 4'b0000, "door_top");
    cyc(0, 4'b0000, 3, 1, 0, C_IDLE, 4'b0000, "top_close");

    // End stop without a call, then press/clear collision at floor 2
    cyc(0, 4'b0000, 0, 1, 0, C_IDLE, 4'b0000, "reposition2");
    cyc(0, 4'b0100, 0, 1, 0, C_IDLE, 4'b0100, "skip_latch");
    cyc(0, 4'b0000, 0, 1, 0, C_UP,   4'b0100, "skip_start");
    cyc(0, 4'b0000, 3, 1, 0, C_IDLE, 4'b0100, "end_stop");
    cyc(0, 4'b0000, 3, 1, 0, C_DN,   4'b0100, "from_top_down");
    cyc(0, 4'b0100, 2, 1, 0, C_PA,   4'b0100, "stop_f2_held");
    for (int i = 0; i < 3; i++) cyc(0, 4'b0100, 2, 1, 0, C_PA, 4'b0000, "press_clear");
    cyc(0, 4'b0100, 2, 1, 0, C_IDLE, 4'b0000, "no_reopen");
    cyc(0, 4'b0000, 2, 1, 0, C_IDLE, 4'b0000, "idle_f2");

    // Fault while moving up
    cyc(0, 4'b1000, 2, 1, 0, C_IDLE, 4'b1000, "flt_latch");
    cyc(0, 4'b0000, 2, 1, 0, C_UP,   4'b1000, "flt_moving");
    cyc(0, 4'b0000, 3, 1, 1, C_FLT,  4'b0000, "fault_enter");
    for (int i = 0; i < 5; i++) cyc(0, 4'b1111, 3, 1, 0, C_FLT, 4'b0000, "fault_hold");
    cyc(1, 4'b1111, 0, 1, 0, C_IDLE, 4'b0000, "fault_reset");
    cyc(0, 4'b0000, 0, 1, 0, C_IDLE, 4'b0000, "post_reset");

    // Reset mid-motion drops pending calls
    cyc(0, 4'b0010, 0, 1, 0, C_IDLE, 4'b0010, "rm_latch");
    cyc(0, 4'b0000, 0, 1, 0, C_UP,   4'b0010, "rm_moving");
    cyc(1, 4'b0000, 1, 1, 0, C_IDLE, 4'b0000, "rst_motion");
    cyc(0, 4'b0000, 1, 1, 0, C_IDLE, 4'b0000, "no_survivor");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_call_dispatcher.md
Name: elevator_call_dispatcher

Overview:
- Request-side counterpart of the elevator car state machine.
- Latches floor call buttons and tracks pending calls.
- Decides the travel direction and drives the car's command inputs: sobe (up), desce (down) and pa (stop/door, parada).
- Consumes the car's erro flag and current-floor feedback, so it sits between the call panel and the car core.

Parameters:
N_FLOORS, 4, number of served floors (2..16)
FLOOR_W, 2, width of floor index, = ceil(log2(N_FLOORS))
DOOR_CYCLES, 4, clock cycles pa stays high per stop (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
btn  input  N_FLOORS  call buttons, level, bit i = floor i
floor  input  FLOOR_W  current floor index from position sensor
floor_valid  input  1  car aligned at `floor`; floor ignored when 0
erro  input  1  fault flag from car core
sobe  output  1  move-up command
desce  output  1  move-down command
pa  output  1  stop/door-open command
pend  output  N_FLOORS  registered pending-call mask
falha  output  1  sticky fault indicator

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE; pend = 0; door counter = 0; dir_last = UP.
  - sobe = desce = pa = falha = 0.
- Outputs are Moore, decoded from the registered state. sobe and desce are never high together.
- Request latch:
  - Each cycle: pend <= pend | btn.
  - In DOOR with floor_valid, bit pend[floor] is forced to 0. Clear wins over a simultaneous press of the same floor.
- States: IDLE, UP, DOWN, DOOR, FAULT.
  - IDLE (all outputs 0), when floor_valid and pend != 0:
    - pend[floor] = 1 -> DOOR.
    - else any pending above floor -> UP.
    - else -> DOWN.
  - UP (sobe=1):
    - floor_valid & pend[floor] -> DOOR, dir_last = UP.
    - floor_valid & floor = N_FLOORS-1 with no call there -> IDLE (end stop).
  - DOWN (desce=1):
    - floor_valid & pend[floor] -> DOOR, dir_last = DOWN.
    - floor_valid & floor = 0 with no call there -> IDLE.
  - DOOR (pa=1):
    - Counter loads DOOR_CYCLES-1 on entry and decrements each cycle.
    - At 0, direction is chosen in this order:
      1. dir_last = UP & calls above -> UP.
      2. dir_last = DOWN & calls below -> DOWN.
      3. otherwise any calls above -> UP; any below -> DOWN.
      4. none -> IDLE.
  - FAULT (pa=1, falha=1, sobe=desce=0):
    - Entered from any state when erro=1 is sampled; erro has priority over all other transitions.
    - pend is cleared and held at 0 (btn ignored).
    - Exits only via rst.
- "Above"/"below" = any pend bit with index >, < floor. Both use the latched floor value when floor_valid=0.
- Latency: btn high at edge k -> pend bit set after edge k -> state change and command after edge k+1.
- rst mid-motion or in DOOR aborts immediately, to the reset values on the next edge. No pending call survives.
- floor >= N_FLOORS while floor_valid=1 is treated as erro (-> FAULT).

Test Plan (N_FLOORS=4, DOOR_CYCLES=4):
- Reset then idle: rst 1 cycle, btn=0 -> sobe=desce=pa=falha=0, pend=0000 held for 20 cycles.
- Call above: floor=0 valid, btn=1000 one cycle -> pend=1000 next cycle, sobe=1 the cycle after. Step floor 1,2,3 -> at floor 3: pa=1 exactly 4 cycles, pend=0000, then IDLE.
- Call at current floor while idle: floor=2, btn=0100 -> DOOR, pa=1 for 4 cycles, sobe/desce never asserted.
- Direction preference, dir_last=UP:
  - Car at floor 1 in DOOR after an up stop, pend=1001 -> after door closes, sobe=1.
  - Reaching floor 3 -> stop there, then desce=1 toward floor 0.
- Simultaneous press/clear: in DOOR at floor 2, btn=0100 held -> pend[2] stays 0, no re-open after door closes.
- Fault:
  - erro=1 for one cycle while sobe=1 -> next cycle sobe=0, pa=1, falha=1, pend=0000.
  - btn=1111 ignored; state holds until rst, then all outputs 0.
